// File: rtl/display_scan_sequencer.sv
// display_scan_sequencer
// Scans four 4-bit digits onto a 1-to-4 demux. Each slot lasts DIV cycles;
// the first BLANK cycles keep demux_en low so the outgoing digit never ghosts
// onto the incoming position. Digit updates land in a shadow buffer and are
// copied to the active buffer only while idle or on a frame boundary.
//
// Handshake: load is a single-cycle strobe with no back-pressure; each strobe
// overwrites the shadow buffer and marks it pending, so only the latest load
// before a transfer point is ever displayed.
module display_scan_sequencer #(
    parameter int DIV   = 8,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic [1:0]  sel,
    output logic        demux_en,
    output logic [3:0]  nibble_out,
    output logic        frame_done,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLNK  = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);

    // With no blanking a slot starts directly in the drive phase.
    localparam logic [1:0] START_STATE = (BLANK == 0) ? DRIVE : BLNK;
    localparam logic       START_EN    = (BLANK == 0) ? 1'b1 : 1'b0;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [15:0]   shadow;
    logic [15:0]   active;
    logic          pending;

    logic          running;
    logic          boundary;
    logic          apply;
    logic [15:0]   active_next;

    // Slot 0 occupies the most significant nibble.
    function automatic logic [3:0] digit(input logic [15:0] word, input logic [1:0] slot);
        case (slot)
            2'd0:    digit = word[15:12];
            2'd1:    digit = word[11:8];
            2'd2:    digit = word[7:4];
            default: digit = word[3:0];
        endcase
    endfunction

    // Frame boundary decode and shadow-to-active transfer decision.
    always_comb begin
        running     = (state != IDLE);
        boundary    = running && (cnt == CNT_LAST) && (sel == 2'b11);
        apply       = pending && (!running || boundary);
        active_next = apply ? shadow : active;
    end

    assign frame_done = boundary;
    assign fsm_state  = state;

    // Double buffer: a load coinciding with a transfer goes to the shadow and
    // stays pending, while active takes the previous shadow contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            active <= active_next;
            if (load) begin
                shadow  <= data_in;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // Scan state machine: slot counter, select, enable and digit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 2'b00;
            demux_en   <= 1'b0;
            nibble_out <= 4'h0;
        end else begin
            case (state)
                BLNK, DRIVE: begin
                    if (!en) begin
                        // Abandon the partial frame and return to idle outputs.
                        state      <= IDLE;
                        cnt        <= '0;
                        sel        <= 2'b00;
                        demux_en   <= 1'b0;
                        nibble_out <= 4'h0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= START_STATE;
                        cnt        <= '0;
                        sel        <= sel + 2'd1;
                        demux_en   <= START_EN;
                        nibble_out <= digit(active_next, sel + 2'd1);
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (state == BLNK && cnt == BLANK_LAST) begin
                            state    <= DRIVE;
                            demux_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (en) begin
                        state      <= START_STATE;
                        cnt        <= '0;
                        sel        <= 2'b00;
                        demux_en   <= START_EN;
                        nibble_out <= digit(active_next, 2'b00);
                    end else begin
                        state      <= IDLE;
                        cnt        <= '0;
                        sel        <= 2'b00;
                        demux_en   <= 1'b0;
                        nibble_out <= 4'h0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Bench for display_scan_sequencer: a frame-position reference model predicts
// every output from elapsed cycles and the buffered digits.
module tb_display_scan_sequencer;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [1:0]  sel;
    logic        demux_en;
    logic [3:0]  nibble_out;
    logic        frame_done;
    logic [1:0]  fsm_state;

    logic        en2;
    logic        load2;
    logic [15:0] data2;
    logic [1:0]  sel2;
    logic        demux_en2;
    logic [3:0]  nibble2;
    logic        frame_done2;
    logic [1:0]  fsm_state2;

    int n_vec;
    int n_err;

    // reference model state
    bit          m_run;
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pending;

    logic [3:0]  exp_q[$];

    display_scan_sequencer #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .data_in(data_in),
        .sel(sel), .demux_en(demux_en), .nibble_out(nibble_out),
        .frame_done(frame_done), .fsm_state(fsm_state)
    );

    display_scan_sequencer #(.DIV(2), .BLANK(0)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .load(load2), .data_in(data2),
        .sel(sel2), .demux_en(demux_en2), .nibble_out(nibble2),
        .frame_done(frame_done2), .fsm_state(fsm_state2)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_digit(input logic [15:0] word, input int slot);
        logic [15:0] sh;
        sh = word >> (4 * (3 - slot));
        return sh[3:0];
    endfunction

    // Expected {sel, demux_en, nibble_out, frame_done} from frame position.
    function automatic logic [7:0] model_out();
        int slot;
        int pos;
        if (!m_run) return 8'h00;
        slot = (m_t / DIV) % 4;
        pos  = m_t % DIV;
        return {2'(slot), (pos >= BLANK) ? 1'b1 : 1'b0, ref_digit(m_active, slot),
                (m_t == FRAME - 1) ? 1'b1 : 1'b0};
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_active = '0; m_shadow = '0; m_pending = 0;
    endtask

    // Advance the model by one clock using the inputs sampled at this edge.
    task automatic model_edge();
        bit boundary;
        bit apply;
        boundary = m_run && (m_t == FRAME - 1);
        apply    = m_pending && (!m_run || boundary);
        if (apply) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        if (load) begin
            m_shadow  = data_in;
            m_pending = 1;
        end
        if (en) begin
            if (m_run) m_t = (m_t + 1) % FRAME;
            else begin m_run = 1; m_t = 0; end
        end else begin
            m_run = 0; m_t = 0;
        end
    endtask

    // One clock: advance model, settle, release the load strobe.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] act;
        act = {sel, demux_en, nibble_out, frame_done};
        n_vec++;
        if (act !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 00", act);
        end
        n_vec++;
        if ({sel2, demux_en2, nibble2, frame_done2} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs2: got %h expected 00", {sel2, demux_en2, nibble2, frame_done2});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== model_out()) begin
                n_err++;
                $display("FAIL idle_hold: cycle %0d got %h expected %h", i, act, model_out());
            end
        end
    endtask

    task automatic test_scan_order();
        logic [7:0] act;
        int prev_sel;
        int last_fd;
        data_in = 16'h1234; load = 1'b1;
        tick();
        en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(4'h1); exp_q.push_back(4'h2);
            exp_q.push_back(4'h3); exp_q.push_back(4'h4);
        end
        prev_sel = -1;
        last_fd  = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== model_out()) begin
                n_err++;
                $display("FAIL scan_order: cycle %0d got %h expected %h", i, act, model_out());
            end
            if (int'(sel) != prev_sel) begin
                prev_sel = int'(sel);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scan_seq: unexpected slot change at cycle %0d", i);
                end else if (nibble_out !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL scan_seq: got %h expected %h", nibble_out, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (frame_done) begin
                if (last_fd >= 0) begin
                    n_vec++;
                    if (i - last_fd != FRAME) begin
                        n_err++;
                        $display("FAIL frame_period: got %0d expected %0d", i - last_fd, FRAME);
                    end
                end
                last_fd = i;
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scan_seq_left: got %0d leftover expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_double_buffer();
        logic [7:0] act;
        int guard;
        guard = 0;
        while (!(m_run && m_t == DIV + 2) && guard < 200) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL dbuf_wait: got timeout expected slot 1");
        end
        data_in = 16'hABCD; load = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== model_out()) begin
                n_err++;
                $display("FAIL double_buffer: cycle %0d got %h expected %h", i, act, model_out());
            end
        end
    endtask

    task automatic test_load_at_boundary();
        logic [7:0] act;
        int guard;
        guard = 0;
        while (!(m_run && m_t == 5) && guard < 200) begin
            tick();
            guard++;
        end
        data_in = 16'h1111; load = 1'b1;
        while (!(m_run && m_t == FRAME - 1) && guard < 200) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== model_out()) begin
                n_err++;
                $display("FAIL boundary_pre: got %h expected %h", act, model_out());
            end
            guard++;
        end
        n_vec++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL boundary_wait: got timeout expected frame end");
        end
        n_vec++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL boundary_pulse: got %b expected 1", frame_done);
        end
        data_in = 16'h2222; load = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== model_out()) begin
                n_err++;
                $display("FAIL load_boundary: cycle %0d got %h expected %h", i, act, model_out());
            end
        end
    endtask

    task automatic test_en_drop();
        logic [7:0] act;
        int guard;
        guard = 0;
        while (!(m_run && m_t == 2 * DIV + 5) && guard < 200) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL en_drop_wait: got timeout expected slot 2");
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== 8'h00) begin
                n_err++;
                $display("FAIL en_drop_idle: cycle %0d got %h expected 00", i, act);
            end
        end
        en = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== model_out()) begin
                n_err++;
                $display("FAIL en_restart: cycle %0d got %h expected %h", i, act, model_out());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] act;
        for (int i = 0; i < 800; i++) begin
            en      = ($urandom_range(0, 99) < 96);
            load    = ($urandom_range(0, 11) == 0);
            data_in = 16'($urandom);
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== model_out()) begin
                n_err++;
                $display("FAIL random: cycle %0d got %h expected %h", i, act, model_out());
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] act;
        int guard;
        en = 1'b1;
        guard = 0;
        while (!(m_run && m_t == 3) && guard < 200) begin
            tick();
            guard++;
        end
        n_vec++;
        if (demux_en !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: got demux_en %b expected 1", demux_en);
        end
        #2;
        reset = 1'b1;
        #1;
        act = {sel, demux_en, nibble_out, frame_done};
        n_vec++;
        if (act !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: got %h expected 00", act);
        end
        model_reset();
        en = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            act = {sel, demux_en, nibble_out, frame_done};
            n_vec++;
            if (act !== 8'h00) begin
                n_err++;
                $display("FAIL post_reset_idle: cycle %0d got %h expected 00", i, act);
            end
        end
        // cleared active buffer: restart shows zeros
        en = 1'b1;
        tick();
        act = {sel, demux_en, nibble_out, frame_done};
        n_vec++;
        if (act !== model_out()) begin
            n_err++;
            $display("FAIL post_reset_start: got %h expected %h", act, model_out());
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_blank0();
        logic [7:0]  act;
        logic [7:0]  expv;
        logic [15:0] word;
        int          slot;
        word  = 16'h5A3C;
        data2 = word; load2 = 1'b1;
        @(posedge clk); #1;
        load2 = 1'b0;
        en2   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            slot = (k / 2) % 4;
            expv = {2'(slot), 1'b1, ref_digit(word, slot), (k % 8 == 7) ? 1'b1 : 1'b0};
            act  = {sel2, demux_en2, nibble2, frame_done2};
            n_vec++;
            if (act !== expv) begin
                n_err++;
                $display("FAIL blank0: cycle %0d got %h expected %h", k, act, expv);
            end
        end
        en2 = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; en = 1'b0; load = 1'b0; data_in = '0;
        en2 = 1'b0; load2 = 1'b0; data2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_scan_order();
        test_double_buffer();
        test_load_at_boundary();
        test_en_drop();
        test_random();
        test_async_reset();
        test_blank0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
